ula_doa_peak_search: RTL
========================

# ula_doa_peak_search

Sequential controller and argmax stage that sits directly around `sq_abs_cmul_4ch` in the ULA DOA chain. It accepts one 4-channel I/Q snapshot and holds it on the power unit's sample inputs. It then sweeps the steering-vector ROM address over all candidate angles and reads back the combinational beam power for each angle. It reports the angle index with the largest power, and that power, over a valid/ready handshake.

## Interface
- `WORD_LENGTH_IN`, 16, width of each I or Q sample and steering component (two's complement)
- `WORD_LENGTH_POW`, 80, width of the power word from the power unit (2·(2·WORD_LENGTH_IN+8)), unsigned
- `N_ANGLES`, 181, number of steering vectors in ROM (indices 0..N_ANGLES-1)
- `ANGLE_W`, 8, width of angle index; must satisfy 2^ANGLE_W ≥ N_ANGLES
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous reset, active high
- `in_valid`  in  1  snapshot offered
- `in_ready`  out  1  block can accept a snapshot
- `x_in`  in  8·WORD_LENGTH_IN  packed {I_x1,I_x2,I_x3,I_x4,Q_x1,Q_x2,Q_x3,Q_x4}, MSB first
- `x_hold`  out  8·WORD_LENGTH_IN  registered snapshot driven to the power unit, same packing
- `steer_addr`  out  ANGLE_W  steering ROM address; ROM is registered (data one cycle after address)
- `pow_in`  in  WORD_LENGTH_POW  power unit result for the current x_hold and ROM data
- `out_valid`  out  1  result available
- `out_ready`  in  1  consumer accepts result
- `peak_idx`  out  ANGLE_W  angle index of maximum power
- `peak_pow`  out  WORD_LENGTH_POW  maximum power

## Operation
- FSM states: IDLE, SCAN, DONE. Reset state: IDLE.
- Reset values: `in_ready`=1, `out_valid`=0, `x_hold`=0, `steer_addr`=0, `peak_idx`=0, `peak_pow`=0.
- IDLE: `in_ready`=1. When `in_valid`&&`in_ready`, capture `x_in` into `x_hold` and go to SCAN. The address counter starts at 0, the compare-index counter at 0, and the running max at 0.
- SCAN: `in_ready`=0.
  - `steer_addr` increments by 1 each cycle from 0 to N_ANGLES-1 and then holds at N_ANGLES-1. It never wraps.
  - Each cycle the compare pipeline samples `pow_in` for angle k = (compare counter).
  - If `pow_in` > running max (strict, unsigned), the running max and its index are updated. On equal powers the lower index wins.
  - After angle N_ANGLES-1 is compared, go to DONE.
- DONE: `out_valid`=1. `peak_idx` and `peak_pow` hold the final values and stay stable until `out_valid`&&`out_ready`; then go to IDLE.
- All-zero power: result is `peak_idx`=0, `peak_pow`=0.
- `in_valid` outside IDLE is ignored; the snapshot is not captured.
- `rst` asserted at any point, including mid-SCAN or in DONE: immediately return to the reset values; the partial result is discarded.
- `x_hold` is constant for the whole SCAN and DONE period.

## Timing
- Handshake on `in_valid`/`in_ready` completes at edge T (end of cycle T).
- Cycle T+1: state SCAN, `steer_addr`=0.
- Cycle T+1+a: `steer_addr`=a.
- Cycle T+2+a: ROM data and `pow_in` are valid for angle a and are compared at the end of that cycle.
- Last compare happens in cycle T+N_ANGLES+1; `out_valid` rises in cycle T+N_ANGLES+2. Latency from accept to result is N_ANGLES+2 cycles (183 with defaults).
- `in_ready` returns high in the cycle after the result handshake. Back-to-back throughput is one snapshot per N_ANGLES+3 cycles when `out_ready` is tied high.
- `pow_in` is sampled only during compare cycles; its value in any other cycle has no effect.

## Structure
- Shared package `ula_doa_pkg` holds:
  - constants: WORD_LENGTH_IN, WORD_LENGTH_POW, N_ANGLES, ANGLE_W
  - FSM state encoding (IDLE=0, SCAN=1, DONE=2)
  - the x-bus packing order
- Sub-module `ula_doa_argmax` holds the running max/index register and the strict-greater compare, with inputs clear, en, idx, pow.
- The FSM and counters live in the top.

## Test plan
- Single snapshot, ROM returns `pow_in` = angle index (monotonic ramp) → `peak_idx`=180, `peak_pow`=180, `out_valid` exactly 183 cycles after accept.
- Peak at angle 45 = 1000, all others 10 → `peak_idx`=45, `peak_pow`=1000.
- Tie: angles 30 and 90 both 500, rest 0 → `peak_idx`=30.
- `out_ready` low for 20 cycles in DONE → outputs stable, `in_ready`=0, and a new `in_valid` is ignored; after `out_ready`, `in_ready`=1 on the next cycle.
- `rst` pulsed at `steer_addr`=50 → all outputs at reset values that cycle. A new snapshot then yields a correct result with no residue from the aborted scan.
- Power values with MSB set (≥2^79) against smaller values → treated as unsigned; the MSB-set entry wins.

Source files
------------

// File: rtl/ula_doa_pkg.sv
// Shared constants, FSM encoding and snapshot bus layout for the ULA DOA
// peak search.
package ula_doa_pkg;

    localparam int WORD_LENGTH_IN  = 16;
    localparam int WORD_LENGTH_POW = 2 * (2 * WORD_LENGTH_IN + 8);
    localparam int N_ANGLES        = 181;
    localparam int ANGLE_W         = 8;
    localparam int X_W             = 8 * WORD_LENGTH_IN;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Snapshot bus, MSB first: all I lanes then all Q lanes.
    typedef struct packed {
        logic [WORD_LENGTH_IN-1:0] i_x1;
        logic [WORD_LENGTH_IN-1:0] i_x2;
        logic [WORD_LENGTH_IN-1:0] i_x3;
        logic [WORD_LENGTH_IN-1:0] i_x4;
        logic [WORD_LENGTH_IN-1:0] q_x1;
        logic [WORD_LENGTH_IN-1:0] q_x2;
        logic [WORD_LENGTH_IN-1:0] q_x3;
        logic [WORD_LENGTH_IN-1:0] q_x4;
    } x_bus_t;

endpackage

// File: rtl/ula_doa_argmax.sv
// Running maximum of beam power and the angle index where it occurred.
// Strict compare keeps the lowest index on ties.
import ula_doa_pkg::*;

module ula_doa_argmax #(
    parameter int IDX_W = ANGLE_W,
    parameter int POW_W = WORD_LENGTH_POW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    input  logic [IDX_W-1:0] idx,
    input  logic [POW_W-1:0] pow,
    output logic [IDX_W-1:0] max_idx,
    output logic [POW_W-1:0] max_pow
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_idx <= '0;
            max_pow <= '0;
        end else if (clear) begin
            max_idx <= '0;
            max_pow <= '0;
        end else if (en && (pow > max_pow)) begin
            max_idx <= idx;
            max_pow <= pow;
        end
    end

endmodule

// File: rtl/ula_doa_peak_search.sv
// Holds one snapshot on the power unit, sweeps the steering ROM and
// returns the angle with the largest beam power over valid/ready.
import ula_doa_pkg::*;

module ula_doa_peak_search #(
    parameter int WORD_LENGTH_IN  = ula_doa_pkg::WORD_LENGTH_IN,
    parameter int WORD_LENGTH_POW = ula_doa_pkg::WORD_LENGTH_POW,
    parameter int N_ANGLES        = ula_doa_pkg::N_ANGLES,
    parameter int ANGLE_W         = ula_doa_pkg::ANGLE_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [8*WORD_LENGTH_IN-1:0] x_in,
    output logic [8*WORD_LENGTH_IN-1:0] x_hold,
    output logic [ANGLE_W-1:0]          steer_addr,
    input  logic [WORD_LENGTH_POW-1:0]  pow_in,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [ANGLE_W-1:0]          peak_idx,
    output logic [WORD_LENGTH_POW-1:0]  peak_pow
);

    localparam logic [ANGLE_W-1:0] LAST = ANGLE_W'(N_ANGLES - 1);

    state_t             state;
    logic [ANGLE_W-1:0] cmp_idx;
    logic               cmp_en;
    logic               accept;

    assign accept = (state == IDLE) && in_valid;

    // cmp_en lags the address by one cycle to match the registered ROM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            x_hold     <= '0;
            steer_addr <= '0;
            cmp_idx    <= '0;
            cmp_en     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_hold     <= x_in;
                        steer_addr <= '0;
                        cmp_idx    <= '0;
                        cmp_en     <= 1'b0;
                        in_ready   <= 1'b0;
                        state      <= SCAN;
                    end
                end
                SCAN: begin
                    if (steer_addr != LAST)
                        steer_addr <= steer_addr + 1'b1;
                    if (!cmp_en) begin
                        cmp_en <= 1'b1;
                    end else if (cmp_idx == LAST) begin
                        cmp_en    <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cmp_idx <= cmp_idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    ula_doa_argmax #(
        .IDX_W (ANGLE_W),
        .POW_W (WORD_LENGTH_POW)
    ) u_argmax (
        .clk     (clk),
        .rst     (rst),
        .clear   (accept),
        .en      (cmp_en),
        .idx     (cmp_idx),
        .pow     (pow_in),
        .max_idx (peak_idx),
        .max_pow (peak_pow)
    );

endmodule
